mem_test_ctrl: RTL

//  Bus initiator for the synchronous 8x32 memory: drives clk-domain read/write/addr/data_in.

---
 rtl/mem_test_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mem_test_ctrl.sv
// -----------------------------------------------------------------------------
// mem_test_ctrl
//   Self-test bus master for a small synchronous memory. It writes a selected
//   pattern to every address, reads every address back, and compares the
//   returned data against the pattern. When the sweep ends it reports the
//   result: pass/fail, the number of bad addresses, and the first bad address.
//
// Ports
//   clk        in   sole clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   start      in   begins a test; only accepted in IDLE or DONE
//   pat_sel    in   pattern select, latched when the test starts
//                   0: addr   1: ~addr   2: addr[0] ? 55 : AA   3: SEED
//   read       out  memory read strobe
//   write      out  memory write strobe
//   addr       out  memory address
//   data_in    out  write data sent to the memory
//   data_out   in   read data, valid the cycle after a read is sampled
//   busy       out  test in progress (WRITE, READ, DRAIN)
//   done       out  test finished, results are valid
//   pass       out  high in DONE when no mismatch was seen
//   err_cnt    out  number of mismatching addresses (0..2**ADDR_W)
//   first_err  out  address of the first mismatch, 0 if there was none
// -----------------------------------------------------------------------------
module mem_test_ctrl #(
  parameter int                ADDR_W = 5,
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] SEED   = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        pat_sel,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  // Pattern value for an address. The address is zero-extended to the data
  // width before inversion, so mode 1 sets the upper data bits.
  function automatic logic [DATA_W-1:0] pat_f(input logic [1:0]        sel,
                                              input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] ext;
    ext = DATA_W'(a);
    case (sel)
      2'd0:    return ext;
      2'd1:    return ~ext;
      2'd2:    return a[0] ? {(DATA_W/2){2'b01}} : {(DATA_W/2){2'b10}};
      default: return SEED;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        pat_q, pat_d;
  // One-stage compare pipeline: what was read last cycle and what it must be.
  logic              cmp_valid_q, cmp_valid_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  logic [DATA_W-1:0] cmp_exp_q, cmp_exp_d;
  logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] first_err_q, first_err_d;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    pat_d       = pat_q;
    cmp_valid_d = 1'b0;
    cmp_addr_d  = cmp_addr_q;
    cmp_exp_d   = cmp_exp_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    read        = 1'b0;
    write       = 1'b0;
    data_in     = '0;
    busy        = 1'b0;
    done        = 1'b0;
    pass        = 1'b0;

    // Compare the data that belongs to last cycle's read. This also covers
    // the DRAIN cycle, where the read of the last address comes back.
    if (cmp_valid_q && (data_out != cmp_exp_q)) begin
      err_cnt_d = err_cnt_q + (ADDR_W+1)'(1);
      if (err_cnt_q == '0) begin
        first_err_d = cmp_addr_q;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        pass = done && (err_cnt_q == '0);
        if (start) begin
          state_d     = S_WRITE;
          pat_d       = pat_sel;
          addr_d      = '0;
          err_cnt_d   = '0;
          first_err_d = '0;
        end
      end

      S_WRITE: begin
        busy    = 1'b1;
        write   = 1'b1;
        data_in = pat_f(pat_q, addr_q);
        if (addr_q == ADDR_LAST) begin
          state_d = S_READ;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end

      S_READ: begin
        busy        = 1'b1;
        read        = 1'b1;
        cmp_valid_d = 1'b1;
        cmp_addr_d  = addr_q;
        cmp_exp_d   = pat_f(pat_q, addr_q);
        if (addr_q == ADDR_LAST) begin
          state_d = S_DRAIN;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end

      S_DRAIN: begin
        busy    = 1'b1;
        state_d = S_DONE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign addr      = addr_q;
  assign err_cnt   = err_cnt_q;
  assign first_err = first_err_q;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      pat_q       <= '0;
      cmp_valid_q <= 1'b0;
      cmp_addr_q  <= '0;
      cmp_exp_q   <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pat_q       <= pat_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_exp_q   <= cmp_exp_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
    end
  end

endmodule
